// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - shared states and constants for the instruction-memory loader
package program_loader_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_COUNT,
        ST_HI,
        ST_LO,
        ST_WRITE,
        ST_CHECK,
        ST_START,
        ST_RUN,
        ST_ERR
    } state_t;

    localparam logic [7:0] SYNC_BYTE   = 8'hA5;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_CSUM    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

endpackage

// File: rtl/program_loader_timeout.sv
// rtl/program_loader_timeout.sv - idle-gap down-counter; done when the budget is spent
module loader_timeout #(
    parameter int CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic done
);

    localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [W-1:0] LOAD = W'((CYCLES > 0) ? CYCLES - 1 : 0);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= LOAD;
        end else if (clear) begin
            count <= LOAD;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    // done is a function of the registered count only, so the caller may
    // derive clear from its next-state logic without a combinational loop
    assign done = (CYCLES != 0) && enable && (count == '0);

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - framed byte stream to 16-bit instruction-memory writes and CPU release
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [7:0]            i_byte,
    input  logic                  i_byte_valid,
    output logic                  o_byte_ready,
    input  logic                  i_reload,
    output logic [ADDR_WIDTH-1:0] o_instr_addr,
    output logic [15:0]           o_instr,
    output logic                  o_instr_we,
    output logic                  o_cpu_rst,
    output logic                  o_ON,
    output logic                  o_control_en,
    output logic                  o_busy,
    output logic [1:0]            o_err_code
);

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            csum;
    logic [7:0]            remaining;
    logic [7:0]            hi_byte;
    logic [15:0]           instr;
    logic                  run_on;
    logic                  ctrl_en;
    logic [1:0]            err_code;
    logic                  fire;
    logic                  counting;
    logic                  tmo_done;

    assign o_byte_ready = (state == ST_IDLE) || (state == ST_COUNT) || (state == ST_HI) ||
                          (state == ST_LO)   || (state == ST_CHECK);
    // a reload in the same cycle swallows whatever byte is on the bus
    assign fire     = i_byte_valid && o_byte_ready && !i_reload;
    assign counting = (state == ST_COUNT) || (state == ST_HI) ||
                      (state == ST_LO)    || (state == ST_CHECK);

    loader_timeout #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (i_clk),
        .rst_n  (i_rst),
        .clear  (fire || !counting || i_reload),
        .enable (counting),
        .done   (tmo_done)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (i_reload) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (fire && (i_byte == SYNC_BYTE)) state_next = ST_COUNT;
                ST_COUNT: if (fire) state_next = ST_HI;  else if (tmo_done) state_next = ST_ERR;
                ST_HI:    if (fire) state_next = ST_LO;  else if (tmo_done) state_next = ST_ERR;
                ST_LO:    if (fire) state_next = ST_WRITE; else if (tmo_done) state_next = ST_ERR;
                ST_WRITE: state_next = (remaining == 8'd0) ? ST_CHECK : ST_HI;
                ST_CHECK: begin
                    if (fire) begin
                        state_next = (i_byte == csum) ? ST_START : ST_ERR;
                    end else if (tmo_done) begin
                        state_next = ST_ERR;
                    end
                end
                ST_START: state_next = ST_RUN;
                ST_RUN:   state_next = ST_RUN;
                ST_ERR:   state_next = ST_ERR;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            addr      <= '0;
            csum      <= 8'd0;
            remaining <= 8'd0;
            hi_byte   <= 8'd0;
            instr     <= 16'd0;
            run_on    <= 1'b0;
            ctrl_en   <= 1'b0;
            err_code  <= ERR_NONE;
        end else if (i_reload) begin
            addr     <= '0;
            csum     <= 8'd0;
            run_on   <= 1'b0;
            ctrl_en  <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            case (state)
                ST_IDLE: if (fire && (i_byte == SYNC_BYTE)) begin
                    csum <= 8'd0;
                    addr <= '0;
                end
                ST_COUNT: if (fire) begin
                    remaining <= i_byte;
                    csum      <= csum + i_byte;
                end
                ST_HI: if (fire) begin
                    hi_byte <= i_byte;
                    csum    <= csum + i_byte;
                end
                ST_LO: if (fire) begin
                    instr <= {hi_byte, i_byte};
                    csum  <= csum + i_byte;
                end
                ST_WRITE: begin
                    addr <= addr + 1'b1;
                    if (remaining != 8'd0) remaining <= remaining - 8'd1;
                end
                default: ;
            endcase
            if ((state_next == ST_ERR) && (state != ST_ERR)) begin
                err_code <= (state == ST_CHECK && fire) ? ERR_CSUM : ERR_TIMEOUT;
            end
            run_on  <= (state_next == ST_RUN);
            ctrl_en <= (state_next == ST_RUN);
        end
    end

    assign o_instr_addr = addr;
    assign o_instr      = instr;
    assign o_instr_we   = (state == ST_WRITE);
    assign o_cpu_rst    = (state == ST_START);
    assign o_ON         = run_on;
    assign o_control_en = ctrl_en;
    assign o_busy       = (state == ST_COUNT) || (state == ST_HI) || (state == ST_LO) ||
                          (state == ST_WRITE) || (state == ST_CHECK) || (state == ST_START);
    assign o_err_code   = err_code;

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed self-checking bench for program_loader
module tb_program_loader;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic [7:0]  i_byte = 8'd0;
    logic        i_byte_valid = 1'b0;
    logic        o_byte_ready;
    logic        i_reload = 1'b0;
    logic [7:0]  o_instr_addr;
    logic [15:0] o_instr;
    logic        o_instr_we;
    logic        o_cpu_rst;
    logic        o_ON;
    logic        o_control_en;
    logic        o_busy;
    logic [1:0]  o_err_code;

    int total = 0;
    int bad   = 0;
    int wr_count  = 0;
    int rst_count = 0;
    int wr_base;
    int rst_base;

    program_loader #(
        .ADDR_WIDTH     (8),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_byte       (i_byte),
        .i_byte_valid (i_byte_valid),
        .o_byte_ready (o_byte_ready),
        .i_reload     (i_reload),
        .o_instr_addr (o_instr_addr),
        .o_instr      (o_instr),
        .o_instr_we   (o_instr_we),
        .o_cpu_rst    (o_cpu_rst),
        .o_ON         (o_ON),
        .o_control_en (o_control_en),
        .o_busy       (o_busy),
        .o_err_code   (o_err_code)
    );

    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        if (o_instr_we) wr_count  <= wr_count + 1;
        if (o_cpu_rst)  rst_count <= rst_count + 1;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Presents one byte and returns 1 time unit after the accepting edge
    task automatic send(input logic [7:0] b);
        int n;
        @(negedge i_clk);
        i_byte = b;
        i_byte_valid = 1'b1;
        n = 0;
        while (!o_byte_ready && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        chk("ready_before_send", {15'd0, o_byte_ready}, 16'd1);
        @(posedge i_clk);
        #1;
        i_byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] a);
        send(hi);
        send(lo);
        chk("we_after_lo", {15'd0, o_instr_we}, 16'd1);
        chk("instr", o_instr, {hi, lo});
        chk("instr_addr", {8'd0, o_instr_addr}, {8'd0, a});
    endtask

    task automatic reload();
        @(negedge i_clk);
        i_reload = 1'b1;
        step();
        i_reload = 1'b0;
        chk("reload_on", {15'd0, o_ON}, 16'd0);
        chk("reload_ctrl", {15'd0, o_control_en}, 16'd0);
        chk("reload_err", {14'd0, o_err_code}, 16'd0);
        chk("reload_ready", {15'd0, o_byte_ready}, 16'd1);
        chk("reload_busy", {15'd0, o_busy}, 16'd0);
    endtask

    initial begin
        #12;
        chk("rst_ready", {15'd0, o_byte_ready}, 16'd1);
        chk("rst_we", {15'd0, o_instr_we}, 16'd0);
        chk("rst_cpu_rst", {15'd0, o_cpu_rst}, 16'd0);
        chk("rst_on", {15'd0, o_ON}, 16'd0);
        chk("rst_ctrl", {15'd0, o_control_en}, 16'd0);
        chk("rst_busy", {15'd0, o_busy}, 16'd0);
        chk("rst_err", {14'd0, o_err_code}, 16'd0);
        chk("rst_instr", o_instr, 16'h0000);
        chk("rst_addr", {8'd0, o_instr_addr}, 16'd0);
        @(negedge i_clk);
        i_rst = 1'b1;

        // Valid two-word frame
        wr_base = wr_count;
        rst_base = rst_count;
        send(8'hA5);
        chk("busy_after_sync", {15'd0, o_busy}, 16'd1);
        send(8'h01);
        send_word(8'h12, 8'h34, 8'd0);
        send_word(8'h56, 8'h78, 8'd1);
        send(8'h15);
        chk("start_cpu_rst", {15'd0, o_cpu_rst}, 16'd1);
        chk("start_on", {15'd0, o_ON}, 16'd0);
        step();
        chk("run_on", {15'd0, o_ON}, 16'd1);
        chk("run_ctrl", {15'd0, o_control_en}, 16'd1);
        chk("run_err", {14'd0, o_err_code}, 16'd0);
        chk("run_cpu_rst", {15'd0, o_cpu_rst}, 16'd0);
        chk("run_ready", {15'd0, o_byte_ready}, 16'd0);
        step();
        chk("frame1_writes", 16'(wr_count - wr_base), 16'd2);
        chk("frame1_rst_pulses", 16'(rst_count - rst_base), 16'd1);
        reload();

        // Leading garbage, then a one-word frame: 00+AB+CD = 0x178 -> 0x78
        wr_base = wr_count;
        send(8'h00);
        send(8'hFF);
        send(8'h13);
        chk("garbage_idle", {15'd0, o_busy}, 16'd0);
        send(8'hA5);
        send(8'h00);
        send_word(8'hAB, 8'hCD, 8'd0);
        send(8'h78);
        step();
        chk("garbage_run_on", {15'd0, o_ON}, 16'd1);
        step();
        chk("garbage_writes", 16'(wr_count - wr_base), 16'd1);
        reload();

        // Bad checksum
        wr_base = wr_count;
        rst_base = rst_count;
        send(8'hA5);
        send(8'h01);
        send_word(8'h12, 8'h34, 8'd0);
        send_word(8'h56, 8'h78, 8'd1);
        send(8'h16);
        chk("csum_err", {14'd0, o_err_code}, 16'd1);
        chk("csum_on", {15'd0, o_ON}, 16'd0);
        chk("csum_ready", {15'd0, o_byte_ready}, 16'd0);
        repeat (4) step();
        chk("csum_err_hold", {14'd0, o_err_code}, 16'd1);
        chk("csum_no_rst", 16'(rst_count - rst_base), 16'd0);
        chk("csum_writes", 16'(wr_count - wr_base), 16'd2);
        reload();

        // Timeout after the high byte
        wr_base = wr_count;
        send(8'hA5);
        send(8'h00);
        send(8'h12);
        repeat (7) step();
        chk("tmo_not_yet_err", {14'd0, o_err_code}, 16'd0);
        chk("tmo_not_yet_busy", {15'd0, o_busy}, 16'd1);
        step();
        chk("tmo_err", {14'd0, o_err_code}, 16'd2);
        chk("tmo_busy", {15'd0, o_busy}, 16'd0);
        chk("tmo_on", {15'd0, o_ON}, 16'd0);
        step();
        chk("tmo_writes", 16'(wr_count - wr_base), 16'd0);
        reload();

        // Reload in HI discards the byte presented alongside it
        send(8'hA5);
        send(8'h00);
        @(negedge i_clk);
        i_reload = 1'b1;
        i_byte = 8'hA5;
        i_byte_valid = 1'b1;
        step();
        i_reload = 1'b0;
        i_byte_valid = 1'b0;
        chk("hi_reload_busy", {15'd0, o_busy}, 16'd0);
        chk("hi_reload_ready", {15'd0, o_byte_ready}, 16'd1);
        send(8'hA5);
        send(8'h00);
        send_word(8'h11, 8'h22, 8'd0);
        send(8'h33);
        step();
        chk("hi_reload_run", {15'd0, o_ON}, 16'd1);
        reload();

        // Maximum frame: 256 words, data = address; FF + 0x7F80 -> 0x7F
        wr_base = wr_count;
        send(8'hA5);
        send(8'hFF);
        for (int i = 0; i < 256; i++) send_word(8'h00, 8'(i), 8'(i));
        send(8'h7F);
        chk("max_cpu_rst", {15'd0, o_cpu_rst}, 16'd1);
        step();
        chk("max_run_on", {15'd0, o_ON}, 16'd1);
        chk("max_addr_wrap", {8'd0, o_instr_addr}, 16'd0);
        step();
        chk("max_writes", 16'(wr_count - wr_base), 16'd256);
        reload();

        // Asynchronous reset mid-frame
        send(8'hA5);
        send(8'h00);
        send(8'h12);
        @(negedge i_clk);
        #2;
        i_rst = 1'b0;
        #1;
        chk("arst_busy", {15'd0, o_busy}, 16'd0);
        chk("arst_ready", {15'd0, o_byte_ready}, 16'd1);
        chk("arst_instr", o_instr, 16'h0000);
        chk("arst_we", {15'd0, o_instr_we}, 16'd0);
        chk("arst_on", {15'd0, o_ON}, 16'd0);
        @(negedge i_clk);
        i_rst = 1'b1;
        send(8'hA5);
        send(8'h00);
        send_word(8'h44, 8'h55, 8'd0);
        send(8'h99);
        step();
        chk("arst_fresh_run", {15'd0, o_ON}, 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of the CPU instruction-memory load port.
- Accepts a framed byte stream over a valid/ready handshake and assembles 16-bit instructions, high byte first.
- Drives the CPU's instruction address, data and write-enable inputs.
- On a good checksum, resets the CPU once and releases it to run (asserts ON and control enable).

Parameters:
- ADDR_WIDTH, 8, instruction-memory address width; also the width of the word-count byte's range.
- TIMEOUT_CYCLES, 1024, maximum idle cycles between bytes inside a frame; 0 disables the timeout.

Ports:
- i_clk  in  1  system clock; all state updates on rising edge.
- i_rst  in  1  asynchronous, active-low reset (0 = reset).
- i_byte  in  8  incoming stream byte.
- i_byte_valid  in  1  i_byte is valid.
- o_byte_ready  out  1  loader can accept a byte; a transfer occurs when valid & ready are both high at a rising edge.
- i_reload  in  1  abort or stop, and return to waiting for a new frame.
- o_instr_addr  out  ADDR_WIDTH  instruction-memory write address.
- o_instr  out  16  instruction word to write.
- o_instr_we  out  1  one-cycle write strobe.
- o_cpu_rst  out  1  one-cycle active-high CPU reset pulse.
- o_ON  out  1  CPU fetches from PC (load port released).
- o_control_en  out  1  control-unit enable.
- o_busy  out  1  frame in progress.
- o_err_code  out  2  0 none, 1 checksum, 2 timeout, 3 reserved.

Behaviour:
- Frame format: SYNC (8'hA5), CNT (word count minus 1), then CNT+1 word pairs {HI, LO}, then CHK.
- CHK is the 8-bit mod-256 sum of CNT and all data bytes.
- States: IDLE, COUNT, HI, LO, WRITE, CHECK, START, RUN, ERR.
- Reset values:
  - State IDLE; address counter 0; checksum 0.
  - o_instr 0, o_instr_we 0, o_cpu_rst 0, o_ON 0, o_control_en 0, o_busy 0, o_err_code 0.
  - o_byte_ready is a decode of state, so it is 1 out of reset.
- o_byte_ready = 1 in IDLE, COUNT, HI, LO and CHECK; 0 in WRITE, START, RUN and ERR.
- Per-state transitions (on an accepted byte unless noted):
  - IDLE: non-SYNC bytes are discarded. SYNC -> COUNT; clear checksum and address.
  - COUNT: latch CNT into the remaining-words counter; checksum += byte; -> HI.
  - HI: latch high byte; checksum += byte; -> LO.
  - LO: latch low byte; checksum += byte; -> WRITE.
  - WRITE (exactly 1 cycle): o_instr_we = 1, o_instr = {HI, LO}, o_instr_addr = current address. Then the address increments. If remaining == 0 -> CHECK, else remaining decrements -> HI.
  - CHECK: CHK == checksum -> START. Mismatch -> ERR with o_err_code = 1.
  - START (exactly 1 cycle): o_cpu_rst = 1; -> RUN.
  - RUN: o_ON = 1 and o_control_en = 1, both registered and asserted from the first RUN cycle. Stays until i_reload.
  - ERR: o_ON stays 0; o_err_code holds its value until i_reload.
- Write-port latency: the strobe appears one cycle after the LO handshake. Addresses in a frame are consecutive from 0.
- CNT = 255 writes 256 words. The address wraps to 0 after the last write; this is harmless.
- o_busy = 1 in COUNT through START inclusive.
- Timeout:
  - Counter runs in COUNT, HI, LO and CHECK; it is cleared on every accepted byte and on any state change.
  - Reaching TIMEOUT_CYCLES -> ERR with o_err_code = 2.
- i_reload has priority over every other event in any state:
  - Next state is IDLE; address and checksum are cleared; o_err_code -> 0.
  - o_ON, o_control_en and o_instr_we are deasserted on the next edge.
  - Bytes presented in the same cycle are discarded.
- Asynchronous reset mid-frame or in RUN: outputs take their reset values immediately. Partially written memory is left as is.
- Memory contents written before an ERR are not cleaned up; the CPU is never released without a passing checksum.

Decomposition:
- Package program_loader_pkg holds:
  - the state enum;
  - SYNC_BYTE = 8'hA5;
  - error-code constants ERR_NONE, ERR_CSUM, ERR_TIMEOUT.
- One sub-module, loader_timeout: a parameterised down-counter with clear and enable inputs and a done output, instantiated once.
- FSM, datapath and checksum stay in program_loader.

Test Plan:
- Valid frame: A5, 01, 12, 34, 56, 78, CHK = 01+12+34+56+78 = 0x15.
  - Expected writes: addr 0 = 0x1234 and addr 1 = 0x5678, each o_instr_we one cycle after its LO byte.
  - Then one o_cpu_rst pulse, then o_ON = 1, o_control_en = 1, o_err_code = 0.
- Leading garbage: 00, FF, 13 before A5, followed by a valid one-word frame. Garbage is ignored; a single write to addr 0; RUN is reached.
- Bad checksum: same frame as the first scenario with CHK = 0x16.
  - Both writes still occur; then ERR with o_err_code = 1, o_ON = 0, o_cpu_rst never pulsed.
  - i_reload -> IDLE with o_err_code = 0.
- Timeout (TIMEOUT_CYCLES = 8): send A5, 00, 12, then hold valid low for 8 cycles. Expect ERR, o_err_code = 2, no write strobe.
- Maximum frame: CNT = FF with 256 words of data = address. Expect 256 writes, addr 0 through 255 in order, then a correct RUN entry.
- Reload and reset mid-operation:
  - i_reload in HI or in RUN: the next cycle is IDLE, o_ON = 0, and a fresh frame loads from addr 0.
  - i_rst low mid-frame: outputs go to reset values immediately.
